// File: rtl/elastic_config_loader.sv
// elastic_config_loader
// Decodes a packed configuration image arriving on a valid/stop stream into
// per-PE, per-context config-memory writes. It also maintains each PE's
// mapping_context_max_id and fires one start_exec pulse once the image ends.
module elastic_config_loader #(
   parameter int DATA_WIDTH                 = 32,
   parameter int PE_NUM                     = 16,
   parameter int PE_NUM_BIT_LENGTH          = 4,
   parameter int NEIGHBOR_PE_NUM            = 4,
   parameter int NEIGHBOR_PE_NUM_BIT_LENGTH = 2,
   parameter int OPERATION_BIT_LENGTH       = 4,
   parameter int CONTEXT_SIZE               = 8,
   parameter int CONTEXT_SIZE_BIT_LENGTH    = 3
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [DATA_WIDTH-1:0]                 stream_data,
   input  logic                                  stream_valid,
   output logic                                  stream_stop,
   input  logic                                  reload,
   output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_1,
   output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_2,
   output logic [NEIGHBOR_PE_NUM-1:0]            config_output_PE_index,
   output logic [OPERATION_BIT_LENGTH-1:0]       config_op,
   output logic [DATA_WIDTH-1:0]                 config_const_data,
   output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    config_index,
   output logic [PE_NUM-1:0]                     write_config_data,
   output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    mapping_context_max_id [PE_NUM],
   output logic                                  start_exec,
   output logic                                  loading,
   output logic                                  error
);

   localparam int NB     = NEIGHBOR_PE_NUM_BIT_LENGTH;
   localparam int N      = NEIGHBOR_PE_NUM;
   localparam int OPB    = OPERATION_BIT_LENGTH;
   localparam int PEW    = PE_NUM_BIT_LENGTH;
   localparam int CXW    = CONTEXT_SIZE_BIT_LENGTH;
   localparam int OP_LSB = 2*NB + N;

   // One extra bit so the range checks stay meaningful even when the field
   // can only just encode PE_NUM-1 / CONTEXT_SIZE-1.
   localparam logic [PEW:0] PE_LIMIT  = PE_NUM[PEW:0];
   localparam logic [CXW:0] CTX_LIMIT = CONTEXT_SIZE[CXW:0];

   typedef enum logic [2:0] {
      S_HEADER = 3'd0,
      S_OP     = 3'd1,
      S_CONST  = 3'd2,
      S_START  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t state, state_nxt;
   logic   accept;
   logic   hdr_seen;

   // Header fields taken straight from the stream word
   logic [PEW-1:0]    hdr_pe_id;
   logic [CXW-1:0]    hdr_max_id;
   logic              hdr_last;
   logic              hdr_bad;
   logic [PE_NUM-1:0] hdr_sel;

   // Current PE block
   logic [PEW-1:0]    blk_pe_id;
   logic [CXW-1:0]    blk_max_id;
   logic              blk_last;
   logic              blk_bad;
   logic [CXW-1:0]    ctx;
   logic              ctx_last;

   // Op-word fields held until the matching const word arrives
   logic [NB-1:0]     hold_idx1;
   logic [NB-1:0]     hold_idx2;
   logic [N-1:0]      hold_mask;
   logic [OPB-1:0]    hold_op;

   function automatic logic [PE_NUM-1:0] pe_decode(input logic [PEW-1:0] id);
      logic [PE_NUM-1:0] sel;
      sel = '0;
      for (int p = 0; p < PE_NUM; p++)
         if (id == PEW'(p)) sel[p] = 1'b1;
      return sel;
   endfunction

   assign hdr_pe_id  = stream_data[PEW-1:0];
   assign hdr_max_id = stream_data[8+CXW-1:8];
   assign hdr_last   = stream_data[DATA_WIDTH-1];
   assign hdr_bad    = ({1'b0, hdr_pe_id} >= PE_LIMIT) || ({1'b0, hdr_max_id} >= CTX_LIMIT);
   assign hdr_sel    = pe_decode(hdr_pe_id);
   assign ctx_last   = (ctx == blk_max_id);

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_HEADER;
      else          state <= state_nxt;
   end

   // Next-state decode: advance on each accepted word, START always falls to DONE
   always_comb begin
      state_nxt = state;
      case (state)
         S_HEADER: if (accept) state_nxt = S_OP;
         S_OP:     if (accept) state_nxt = S_CONST;
         S_CONST:  if (accept) begin
                      if (ctx_last) state_nxt = blk_last ? S_START : S_HEADER;
                      else          state_nxt = S_OP;
                   end
         S_START:  state_nxt = S_DONE;
         S_DONE:   if (reload) state_nxt = S_HEADER;
         default:  state_nxt = S_HEADER;
      endcase
   end

   // State-decoded outputs: back-pressure, transfer qualifier, loading flag
   always_comb begin
      stream_stop = (state == S_START) || (state == S_DONE);
      accept      = stream_valid && !stream_stop;
      loading     = hdr_seen && !stream_stop;
   end

   // Block bookkeeping: latch header fields, step the context counter
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         blk_pe_id  <= '0;
         blk_max_id <= '0;
         blk_last   <= 1'b0;
         blk_bad    <= 1'b0;
         ctx        <= '0;
      end else if (state == S_HEADER && accept) begin
         blk_pe_id  <= hdr_pe_id;
         blk_max_id <= hdr_max_id;
         blk_last   <= hdr_last;
         blk_bad    <= hdr_bad;
         ctx        <= '0;
      end else if (state == S_CONST && accept && !ctx_last) begin
         ctx        <= ctx + 1'b1;
      end
   end

   // Op-word holding registers; never observed before they are reloaded
   always_ff @(posedge clk) begin
      if (state == S_OP && accept) begin
         hold_idx1 <= stream_data[NB-1:0];
         hold_idx2 <= stream_data[2*NB-1:NB];
         hold_mask <= stream_data[OP_LSB-1:2*NB];
         hold_op   <= stream_data[OP_LSB+OPB-1:OP_LSB];
      end
   end

   // Config-bus write port: buses update only on a real write and then hold
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         config_input_PE_index_1 <= '0;
         config_input_PE_index_2 <= '0;
         config_output_PE_index  <= '0;
         config_op               <= '0;
         config_const_data       <= '0;
         config_index            <= '0;
         write_config_data       <= '0;
      end else begin
         write_config_data <= '0;
         if (state == S_CONST && accept && !blk_bad) begin
            config_input_PE_index_1 <= hold_idx1;
            config_input_PE_index_2 <= hold_idx2;
            config_output_PE_index  <= hold_mask;
            config_op               <= hold_op;
            config_const_data       <= stream_data;
            config_index            <= ctx;
            write_config_data       <= pe_decode(blk_pe_id);
         end
      end
   end

   // Per-PE max context id, written by every valid header
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int p = 0; p < PE_NUM; p++) mapping_context_max_id[p] <= '0;
      end else if (state == S_HEADER && accept && !hdr_bad) begin
         for (int p = 0; p < PE_NUM; p++)
            if (hdr_sel[p]) mapping_context_max_id[p] <= hdr_max_id;
      end
   end

   // Start pulse, sticky error and the header-seen flag behind loading
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         start_exec <= 1'b0;
         error      <= 1'b0;
         hdr_seen   <= 1'b0;
      end else begin
         start_exec <= (state == S_START) && !error;
         if (state == S_HEADER && accept) begin
            hdr_seen <= 1'b1;
            if (hdr_bad) error <= 1'b1;
         end else if (state == S_START) begin
            hdr_seen <= 1'b0;
         end
         if (state == S_DONE && reload) error <= 1'b0;
      end
   end

endmodule
